// File: rtl/pseudo_softmax_pkg.sv
// Shared types and default sizing for the pseudo-softmax streaming block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pseudo_softmax_pkg;

    localparam int N_MAX_DEF  = 8;
    localparam int IN_W_DEF   = 8;
    localparam int FRAC_W_DEF = 3;
    localparam int EXP_W_DEF  = 4;

    // LOAD collects a vector, EMIT streams one result per element
    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/pseudo_softmax_stream_exp2_split.sv
// Splits a non-positive fixed-point z into 2^-exp * (1 + mant/2^FRAC_W), saturating large exponents.
// Latency: combinational, 0 cycles.
// Backpressure: none, pure function of z.
module exp2_split
    import pseudo_softmax_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int EXP_W  = EXP_W_DEF
) (
    input  logic signed [IN_W:0]   z,
    output logic [EXP_W-1:0]       exp,
    output logic [FRAC_W-1:0]      mant,
    output logic                   sat
);

    // Largest exponent representable on the output field
    localparam logic signed [IN_W:0] E_MAX = (IN_W+1)'((1 << EXP_W) - 1);

    logic signed [IN_W:0] sh;
    logic signed [IN_W:0] e;

    // Floor-divide z by 2^FRAC_W, negate for the exponent, clamp when it overflows
    always_comb begin
        sh   = z >>> FRAC_W;
        e    = -sh;
        exp  = e[EXP_W-1:0];
        mant = z[FRAC_W-1:0];
        sat  = 1'b0;
        if (e > E_MAX) begin
            exp  = '1;
            mant = '0;
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/pseudo_softmax_stream.sv
// Buffers a signed vector, tracks its max, then streams 2^(x_i - max) as (exp, mant) per element.
// Latency: first result valid 1 cycle after the last element is accepted; 1 result/cycle after.
// Backpressure: in_ready low while emitting; results hold while out_valid && !out_ready.
module pseudo_softmax_stream
    import pseudo_softmax_pkg::*;
#(
    parameter int N_MAX  = N_MAX_DEF,
    parameter int IN_W   = IN_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int EXP_W  = EXP_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EXP_W-1:0]  out_exp,
    output logic [FRAC_W-1:0] out_mant,
    output logic              out_last,
    output logic              out_sat,
    output logic              busy
);

    localparam int CNT_W = $clog2(N_MAX + 1);
    localparam int IDX_W = (N_MAX > 1) ? $clog2(N_MAX) : 1;

    state_t                  state;
    logic [CNT_W-1:0]        count;
    logic [IDX_W-1:0]        rd_idx;
    logic signed [IN_W-1:0]  max_r;
    logic signed [IN_W-1:0]  buf_mem [N_MAX];

    logic signed [IN_W-1:0]  x_in;
    logic signed [IN_W-1:0]  max_next;
    logic signed [IN_W-1:0]  src_x;
    logic signed [IN_W-1:0]  src_max;
    logic signed [IN_W:0]    z;
    logic [IDX_W-1:0]        nxt_idx;
    logic                    accept;
    logic                    last_in;
    logic                    xfer;
    logic [EXP_W-1:0]        sp_exp;
    logic [FRAC_W-1:0]       sp_mant;
    logic                    sp_sat;

    assign x_in     = in_data;
    assign in_ready = (state == ST_LOAD);
    assign accept   = in_ready && in_valid;
    // A full buffer closes the vector regardless of in_last
    assign last_in  = in_last || (count == CNT_W'(N_MAX - 1));
    assign xfer     = out_valid && out_ready;
    assign busy     = (state != ST_LOAD) || (count != '0);

    // Running max including the element on the input port; the first element seeds it
    always_comb begin
        max_next = max_r;
        if ((count == '0) || (x_in > max_r)) begin
            max_next = x_in;
        end
    end

    // Next read index, wrapped so it never addresses past the buffer
    always_comb begin
        nxt_idx = rd_idx + IDX_W'(1);
        if (rd_idx == IDX_W'(N_MAX - 1)) begin
            nxt_idx = '0;
        end
    end

    // Operand select: element 0 against the final max when closing a vector, otherwise the next element
    always_comb begin
        src_x   = buf_mem[nxt_idx];
        src_max = max_r;
        if (state == ST_LOAD) begin
            src_x   = (count == '0) ? x_in : buf_mem[0];
            src_max = max_next;
        end
    end

    assign z = {src_x[IN_W-1], src_x} - {src_max[IN_W-1], src_max};

    exp2_split #(
        .IN_W   (IN_W),
        .FRAC_W (FRAC_W),
        .EXP_W  (EXP_W)
    ) u_exp2_split (
        .z    (z),
        .exp  (sp_exp),
        .mant (sp_mant),
        .sat  (sp_sat)
    );

    // Element storage; contents are only read after being written, so no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_mem[count[IDX_W-1:0]] <= x_in;
        end
    end

    // FSM, element count, running max and registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_LOAD;
            count     <= '0;
            rd_idx    <= '0;
            max_r     <= '0;
            out_valid <= 1'b0;
            out_exp   <= '0;
            out_mant  <= '0;
            out_last  <= 1'b0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (accept) begin
                        count <= count + CNT_W'(1);
                        max_r <= max_next;
                        if (last_in) begin
                            state     <= ST_EMIT;
                            rd_idx    <= '0;
                            out_valid <= 1'b1;
                            out_exp   <= sp_exp;
                            out_mant  <= sp_mant;
                            out_sat   <= sp_sat;
                            out_last  <= (count == '0);
                        end
                    end
                end
                ST_EMIT: begin
                    if (xfer) begin
                        if (out_last) begin
                            state     <= ST_LOAD;
                            count     <= '0;
                            out_valid <= 1'b0;
                        end else begin
                            rd_idx   <= nxt_idx;
                            out_exp  <= sp_exp;
                            out_mant <= sp_mant;
                            out_sat  <= sp_sat;
                            out_last <= (CNT_W'(nxt_idx) == (count - CNT_W'(1)));
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule
